byte_feed_fifo: RTL



---
 rtl/byte_feed_fifo.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/byte_feed_fifo.sv
// Byte FIFO that feeds an 8-bit data_in/enable consumer with paced one-cycle strobes.
// Optional stats (issued_cnt, hwm) are enabled by defining BYTE_FEED_STATS_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready to issue the next stored byte when count!=0 and !stall
// GAPWAIT | enforcing GAP idle cycles after an issue; stall is ignored here
module byte_feed_fifo #(
    parameter int DEPTH = 16,
    parameter int GAP   = 0,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          stall,
    output logic [7:0]    feed_data,
    output logic          feed_enable,
    output logic [CW-1:0] count,
    output logic          busy
`ifdef BYTE_FEED_STATS_EN
    ,
    output logic [15:0]   issued_cnt,
    output logic [CW-1:0] hwm
`endif
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [7:0]    GAP_C   = 8'(GAP);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GAPWAIT = 1'b1
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_in_ready;
    logic [7:0]    r_feed_data;
    logic          r_feed_enable;
    logic [7:0]    r_gap_cnt;
    state_t        r_state;

    logic          w_push;
    logic          w_issue;
    logic [CW-1:0] w_count_next;

    assign w_push       = in_valid && r_in_ready;
    assign w_issue      = (r_state == ST_IDLE) && (r_count != '0) && !stall;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_issue);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // in_ready looks at the post-edge occupancy, so a full FIFO never accepts
    // even when a pop happens in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next < DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_rd_ptr      <= '0;
            r_gap_cnt     <= '0;
            r_feed_data   <= 8'h00;
            r_feed_enable <= 1'b0;
        end else begin
            r_feed_enable <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_feed_data   <= r_mem[r_rd_ptr];
                        r_feed_enable <= 1'b1;
                        r_rd_ptr      <= r_rd_ptr + AW'(1);
                        if (GAP > 0) begin
                            r_state   <= ST_GAPWAIT;
                            r_gap_cnt <= GAP_C;
                        end
                    end
                end
                ST_GAPWAIT: begin
                    r_gap_cnt <= r_gap_cnt - 8'd1;
                    if (r_gap_cnt <= 8'd1) begin
                        r_state   <= ST_IDLE;
                        r_gap_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign feed_data   = r_feed_data;
    assign feed_enable = r_feed_enable;
    assign count       = r_count;
    assign busy        = (r_count != '0) || (r_state != ST_IDLE);

`ifdef BYTE_FEED_STATS_EN
    logic [15:0]   r_issued_cnt;
    logic [CW-1:0] r_hwm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issued_cnt <= '0;
            r_hwm        <= '0;
        end else begin
            if (w_issue && (r_issued_cnt != 16'hFFFF)) begin
                r_issued_cnt <= r_issued_cnt + 16'd1;
            end
            if (w_count_next > r_hwm) begin
                r_hwm <= w_count_next;
            end
        end
    end

    assign issued_cnt = r_issued_cnt;
    assign hwm        = r_hwm;
`endif

endmodule
